// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one registered W-bit adder
// between NREQ requesters. Each operation runs grant -> operand latch ->
// fixed ADD_LAT wait -> result held under a valid/ready handshake, tagged
// with the id of the requester that was served.
module adder_share_arbiter #(
  parameter int W       = 4,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 2,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_flat,
  input  logic [NREQ*W-1:0]   b_flat,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                res_valid,
  output logic [W:0]          res_sum,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready
);

  // Counter holds ADD_LAT (up to 15) down to 1.
  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  win_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            res_valid_q;
  logic [W:0]      res_sum_q;
  logic [IDW-1:0]  res_id_q;

  logic            pick_vld_d;
  logic [IDW-1:0]  pick_id_d;
  logic [NREQ-1:0] gnt_d;
  logic [IDW-1:0]  ptr_next_d;
  int              scan_idx;

  // Round-robin pick: first set req bit scanning upward from ptr_q with wrap.
  // The scan runs from the farthest offset down so the nearest one wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_id_d  = '0;
    scan_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx   = (int'(ptr_q) + k) % NREQ;
      pick_vld_d = req[scan_idx] ? 1'b1 : pick_vld_d;
      pick_id_d  = req[scan_idx] ? IDW'(scan_idx) : pick_id_d;
    end
    gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_id_d;
    if (win_q == IDW'(NREQ - 1)) begin
      ptr_next_d = '0;
    end else begin
      ptr_next_d = win_q + IDW'(1);
    end
  end

  // Sequencing FSM: arbitration, operand latch, latency count, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_d) begin
            a_q     <= a_flat[int'(pick_id_d)*W +: W];
            b_q     <= b_flat[int'(pick_id_d)*W +: W];
            win_q   <= pick_id_d;
            gnt_q   <= gnt_d;
            cnt_q   <= CW'(ADD_LAT);
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end else begin
            gnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          gnt_q <= '0;
          if (cnt_q == CW'(1)) begin
            // Zero-extend both operands so the carry lands in bit W.
            res_sum_q   <= {1'b0, a_q} + {1'b0, b_q};
            res_id_q    <= win_q;
            res_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          gnt_q <= '0;
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= ptr_next_d;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (W=4, NREQ=4, ADD_LAT=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_flat;
  logic [15:0] b_flat;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [4:0]  res_sum;
  logic [1:0]  res_id;
  logic        res_ready;

  int n_vec;
  int n_err;
  int cyc;
  int last_gnt_cyc;
  logic [3:0] g;

  adder_share_arbiter #(.W(4), .NREQ(4), .ADD_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    a_flat[i*4 +: 4] = a;
    b_flat[i*4 +: 4] = b;
  endtask

  // Advance until a grant pulse is seen, bounded to 20 cycles.
  task automatic wait_gnt(output logic [3:0] gv);
    logic seen;
    seen = 1'b0;
    gv   = 4'b0000;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (gnt != 4'b0000) begin
        seen = 1'b1;
        gv   = gnt;
      end
    end
    if (!seen) check_val("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [4:0] sum, input logic [1:0] id);
    check_val({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check_val({tag, "_sum"},   {27'd0, res_sum},   {27'd0, sum});
    check_val({tag, "_id"},    {30'd0, res_id},    {30'd0, id});
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    last_gnt_cyc = 0;
    req = 4'b0000;
    a_flat = 16'h0000;
    b_flat = 16'h0000;
    res_ready = 1'b0;

    // Reset state.
    rst_pulse();
    check_val("rst_gnt",   {28'd0, gnt},       32'd0);
    check_val("rst_busy",  {31'd0, busy},      32'd0);
    check_val("rst_valid", {31'd0, res_valid}, 32'd0);
    check_val("rst_sum",   {27'd0, res_sum},   32'd0);
    check_val("rst_id",    {30'd0, res_id},    32'd0);

    // Single request: 5 + 3 = 8 from requester 0.
    set_op(0, 4'b0101, 4'b0011);
    req = 4'b0001;
    res_ready = 1'b1;
    wait_gnt(g);
    check_val("single_gnt", {28'd0, g}, 32'h1);
    check_val("single_busy", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    tick();
    check_val("single_gnt_pulse", {28'd0, gnt}, 32'd0);
    check_val("single_lat_not_yet", {31'd0, res_valid}, 32'd0);
    tick();
    check_result("single", 5'b01000, 2'd0);
    tick();
    check_val("single_busy_clr", {31'd0, busy}, 32'd0);
    check_val("single_valid_clr", {31'd0, res_valid}, 32'd0);

    // Round-robin with all requesting; 15 + 15 = 30 every time, 4 cycles apart.
    rst_pulse();
    for (int i = 0; i < 4; i++) set_op(i, 4'b1111, 4'b1111);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      wait_gnt(g);
      check_val("rr_gnt", {28'd0, g}, {28'd0, exp_g});
      if (k > 0) check_val("rr_spacing", cyc - last_gnt_cyc, 32'd4);
      last_gnt_cyc = cyc;
      if (k == 4) req = 4'b0000;
      tick();
      tick();
      check_result("rr", 5'b11110, 2'(k % 4));
    end
    tick();
    check_val("rr_idle", {31'd0, busy}, 32'd0);

    // Backpressure: 7 + 9 = 16 from requester 2 held while res_ready low.
    res_ready = 1'b0;
    set_op(2, 4'b0111, 4'b1001);
    req = 4'b0100;
    wait_gnt(g);
    check_val("bp_gnt", {28'd0, g}, 32'h4);
    req = 4'b1111;
    tick();
    tick();
    check_result("bp", 5'b10000, 2'd2);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_result("bp_hold", 5'b10000, 2'd2);
      check_val("bp_hold_gnt", {28'd0, gnt}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    check_val("bp_accept_valid", {31'd0, res_valid}, 32'd0);
    check_val("bp_accept_gnt", {28'd0, gnt}, 32'd0);
    // Pointer now 3: requester 3 is next.
    wait_gnt(g);
    check_val("bp_next_gnt", {28'd0, g}, 32'h8);
    req = 4'b0101;
    tick();
    tick();
    check_result("wrap3", 5'b11110, 2'd3);

    // Pointer wrap/skip: after 3, req=0101 gives 0 then 2.
    wait_gnt(g);
    check_val("wrap_gnt0", {28'd0, g}, 32'h1);
    tick();
    tick();
    check_result("wrap0", 5'b11110, 2'd0);
    wait_gnt(g);
    check_val("wrap_gnt2", {28'd0, g}, 32'h4);
    req = 4'b0000;
    tick();
    tick();
    check_result("wrap2", 5'b10000, 2'd2);
    tick();

    // Operand change after grant: 3 + 1 = 4 despite a moving to 15.
    set_op(1, 4'b0011, 4'b0001);
    req = 4'b0010;
    wait_gnt(g);
    check_val("opchg_gnt", {28'd0, g}, 32'h2);
    req = 4'b0000;
    tick();
    set_op(1, 4'b1111, 4'b0001);
    tick();
    check_result("opchg", 5'b00100, 2'd1);
    tick();

    // Reset mid-operation: pointer 2 would pick 3; after reset it picks 1.
    req = 4'b1010;
    wait_gnt(g);
    check_val("midrst_gnt", {28'd0, g}, 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_busy",  {31'd0, busy},      32'd0);
    check_val("midrst_valid", {31'd0, res_valid}, 32'd0);
    check_val("midrst_gnt0",  {28'd0, gnt},       32'd0);
    wait_gnt(g);
    check_val("midrst_next_gnt", {28'd0, g}, 32'h2);
    req = 4'b0000;
    tick();
    check_val("midrst_no_stale", {31'd0, res_valid}, 32'd0);
    tick();
    check_result("midrst", 5'b10000, 2'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered W-bit adder between NREQ requesters.
- Arbitration is round-robin.
- Sequences each operation: grant, operand latch, fixed-latency wait, result hold.
- Result is delivered with a valid/ready handshake and tagged with the requester ID.
- Sits between requesting units and the shared add datapath. It is the sequencing/arbitration layer for the delayed adder used across the assignment set.

Parameters:
- W, 4, operand width; sum is W+1 bits.
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 2, adder latency in cycles from operand latch to sum capture (1..15).
- IDW, $clog2(NREQ), requester ID width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request; must be held with stable operands until own gnt bit seen.
- a_flat  input  NREQ*W  operand A; requester i at bits [i*W +: W].
- b_flat  input  NREQ*W  operand B; same packing.
- gnt  output  NREQ  one-hot grant, single-cycle pulse; operands of that requester latched this cycle.
- busy  output  1  high in any state other than IDLE.
- res_valid  output  1  result available.
- res_sum  output  W+1  a+b of the served request, zero-extended add, no overflow loss.
- res_id  output  IDW  index of the served requester.
- res_ready  input  1  consumer accepts result when res_valid && res_ready.

Behaviour:
- Reset (synchronous, rst high at rising edge):
  - state=IDLE, gnt=0, busy=0, res_valid=0, res_sum=0, res_id=0.
  - Round-robin pointer=0, latency counter=0.
  - Applies from any state; an in-flight operation and any held result are discarded with no gnt or res_valid afterwards.
- FSM states: IDLE, WAIT, DONE. The grant pulse is a registered output asserted on the IDLE->WAIT transition.
- IDLE:
  - If req!=0, select the first set bit scanning upward (with wrap) from the pointer.
  - At the clock edge, latch that requester's a/b into internal regs, set gnt one-hot for the following cycle, load counter=ADD_LAT, go to WAIT.
  - If req==0, stay; gnt=0.
- WAIT:
  - gnt is high only in the first WAIT cycle.
  - Counter decrements each cycle.
  - When counter reaches 1, the next edge captures res_sum=a_r+b_r and res_id=winner, sets res_valid=1, and goes to DONE.
- Latency: if gnt is high in cycle C, res_valid is first high in cycle C+ADD_LAT.
- DONE:
  - res_valid, res_sum and res_id are held stable while res_ready=0 (no timeout).
  - On res_valid && res_ready at an edge: res_valid=0, pointer=(winner+1) mod NREQ, go to IDLE.
  - New arbitration occurs in the IDLE cycle after; there is no back-to-back bypass. Minimum issue interval is ADD_LAT+2 cycles.
- req changes while busy are ignored. A requester that drops req before its gnt is not served and causes no error.
- Operand changes after gnt do not affect the in-flight sum.
- The winner's req may stay high after gnt. It is treated as a new request at the next IDLE, subject to the round-robin pointer.
- All outputs are registered; no combinational path from req/a/b/res_ready to any output.
- res_sum width is W+1. Example: 4'hF+4'hF=5'h1E.

Test Plan:
- Reset then single request: rst 2 cycles; req=4'b0001, a=0101, b=0011 -> gnt=0001 one cycle; res_valid 2 cycles later (ADD_LAT=2), res_sum=01000, res_id=0; res_ready=1 returns busy=0 next cycle.
- Round-robin fairness: req=4'b1111 held, res_ready=1, operands all 1111 -> gnt order 0001, 0010, 0100, 1000, 0001; every res_sum=11110; each issue spaced 4 cycles apart.
- Backpressure: req=4'b0100, a=0111, b=1001, res_ready=0 for 6 cycles -> res_valid high and res_sum=10000, res_id=2 held stable; gnt stays 0 for other pending requests until res_ready=1.
- Operand change after grant: req=4'b0010, a=0011, b=0001; change a to 1111 the cycle after gnt -> res_sum=00100, res_id=1.
- Reset mid-operation: assert rst in the WAIT cycle after gnt -> next cycle busy=0, res_valid=0; no result for that request; next grant starts from requester 0.
- Pointer wrap/skip: serve requester 3, then req=4'b0101 -> next gnt=0001, then 0100.
